ssc_clk_mon: RTL and testbench

Receive-side monitor for the spread-spectrum clock. It samples a modulated clock (`mon_clk`) in the `clk_in` domain and counts its rising edges over programmable windows. From those counts it reports the minimum and maximum per-window frequency, the peak-to-peak spread and the number of modulation turning points. It sits on the chip-level clock-monitor path for calibration, production test and EMI-spread compliance checking.

---
 rtl/ssc_pkg.sv | 19 +
 rtl/ssc_edge_sync.sv | 28 ++
 rtl/ssc_clk_mon.sv | 154 +++++++++++++++
 tb/tb_ssc_clk_mon.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ssc_pkg.sv
// Shared types and constants for the spread-spectrum clock monitors.
package ssc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } ssc_mon_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ssc_dir_e;

  localparam int unsigned SSC_SYNC_STAGES = 2;

endpackage

// File: rtl/ssc_edge_sync.sv
// Synchronizes an asynchronous clock into clk_in and emits a one-cycle pulse per rising edge.
module ssc_edge_sync
  import ssc_pkg::*;
#(
  parameter int unsigned STAGES = SSC_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_pulse = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/ssc_clk_mon.sv
// Windowed edge-count monitor for a spread-spectrum clock: min/max count, spread and turning points.
module ssc_clk_mon
  import ssc_pkg::*;
#(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned WIN_W  = 12,
  parameter int unsigned NWIN_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              mon_clk,
  input  logic              mon_start,
  input  logic              mon_abort,
  input  logic [WIN_W-1:0]  mon_win_len,
  input  logic [NWIN_W-1:0] mon_num_win,
  input  logic [CNT_W-1:0]  mon_spread_max,
  output logic              mon_busy,
  output logic              mon_done,
  output logic [CNT_W-1:0]  mon_cnt_min,
  output logic [CNT_W-1:0]  mon_cnt_max,
  output logic [CNT_W-1:0]  mon_spread,
  output logic [NWIN_W-1:0] mon_turns,
  output logic              mon_err,
  output logic [1:0]        mon_dbg_state
);

  ssc_mon_state_e    state_q, state_d;
  logic [WIN_W-1:0]  win_len_q, win_cnt_q;
  logic [NWIN_W-1:0] num_win_q, win_idx_q, turns_q;
  logic [CNT_W-1:0]  spread_max_q, edge_cnt_q;
  logic [CNT_W-1:0]  cnt_min_q, cnt_max_q, prev_q, spread_q;
  ssc_dir_e          dir_q, dir_new, dir_next;
  logic              err_q;

  logic              mon_edge;
  logic              busy, cfg_bad, start_ok, clr_res;
  logic              win_last, last_win, first_win, meas_end, turn_inc;
  logic [CNT_W-1:0]  cnt_now, min_new, max_new, spread_new;

  ssc_edge_sync #(.STAGES(SSC_SYNC_STAGES)) u_edge_sync (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .async_in   (mon_clk),
    .rise_pulse (mon_edge)
  );

  assign busy      = (state_q == SETTLE) || (state_q == MEASURE);
  assign cfg_bad   = (mon_win_len == '0) || (mon_num_win == '0);
  assign start_ok  = (state_q == IDLE) && mon_start;
  assign clr_res   = start_ok || (busy && mon_abort);
  assign win_last  = (win_cnt_q == win_len_q - WIN_W'(1));
  assign last_win  = (win_idx_q == num_win_q - NWIN_W'(1));
  assign first_win = (win_idx_q == '0);
  assign meas_end  = (state_q == MEASURE) && win_last && !mon_abort;

  // Window count includes an edge landing on the window's last cycle.
  assign cnt_now = (mon_edge && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

  always_comb begin
    min_new  = cnt_now;
    max_new  = cnt_now;
    dir_new  = NONE;
    dir_next = NONE;
    turn_inc = 1'b0;
    if (!first_win) begin
      min_new = (cnt_now < cnt_min_q) ? cnt_now : cnt_min_q;
      max_new = (cnt_now > cnt_max_q) ? cnt_now : cnt_max_q;
      if (cnt_now > prev_q)      dir_new = UP;
      else if (cnt_now < prev_q) dir_new = DOWN;
      turn_inc = (dir_new != NONE) && (dir_q != NONE) && (dir_new != dir_q);
      dir_next = (dir_new != NONE) ? dir_new : dir_q;
    end
  end

  assign spread_new = max_new - min_new;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mon_start) state_d = cfg_bad ? DONE : SETTLE;
      SETTLE:  if (mon_abort) state_d = IDLE;
               else if (win_last) state_d = MEASURE;
      MEASURE: if (mon_abort) state_d = IDLE;
               else if (win_last && last_win) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      win_len_q    <= '0;
      num_win_q    <= '0;
      spread_max_q <= '0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      win_idx_q    <= '0;
      cnt_min_q    <= '0;
      cnt_max_q    <= '0;
      prev_q       <= '0;
      spread_q     <= '0;
      turns_q      <= '0;
      dir_q        <= NONE;
      err_q        <= 1'b0;
    end else begin
      if (start_ok) begin
        win_len_q    <= mon_win_len;
        num_win_q    <= mon_num_win;
        spread_max_q <= mon_spread_max;
      end

      win_cnt_q  <= (busy && !win_last && !mon_abort) ? win_cnt_q + WIN_W'(1) : '0;
      edge_cnt_q <= ((state_q == MEASURE) && !win_last && !mon_abort) ? cnt_now : '0;

      if (clr_res) begin
        win_idx_q <= '0;
        cnt_min_q <= '0;
        cnt_max_q <= '0;
        prev_q    <= '0;
        spread_q  <= '0;
        turns_q   <= '0;
        dir_q     <= NONE;
        err_q     <= start_ok && cfg_bad;
      end else if (meas_end) begin
        win_idx_q <= win_idx_q + NWIN_W'(1);
        cnt_min_q <= min_new;
        cnt_max_q <= max_new;
        prev_q    <= cnt_now;
        dir_q     <= dir_next;
        if (turn_inc && (turns_q != '1)) turns_q <= turns_q + NWIN_W'(1);
        // Spread and limit check use the final window's min/max so they are valid in DONE.
        if (last_win) begin
          spread_q <= spread_new;
          err_q    <= (spread_new > spread_max_q);
        end
      end
    end
  end

  assign mon_busy      = busy;
  assign mon_done      = (state_q == DONE);
  assign mon_cnt_min   = cnt_min_q;
  assign mon_cnt_max   = cnt_max_q;
  assign mon_spread    = spread_q;
  assign mon_turns     = turns_q;
  assign mon_err       = err_q;
  assign mon_dbg_state = state_q;

endmodule

// File: tb/tb_ssc_clk_mon.sv
// Directed self-checking bench for ssc_clk_mon with hand-computed expectations.
module tb_ssc_clk_mon;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_clk = 1'b0;
  logic        mon_start = 1'b0;
  logic        mon_abort = 1'b0;
  logic [11:0] mon_win_len = '0;
  logic [7:0]  mon_num_win = '0;
  logic [11:0] mon_spread_max = '0;
  logic        mon_busy, mon_done, mon_err;
  logic [11:0] mon_cnt_min, mon_cnt_max, mon_spread;
  logic [7:0]  mon_turns;
  logic [1:0]  mon_dbg_state;

  ssc_clk_mon #(.CNT_W(12), .WIN_W(12), .NWIN_W(8)) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .mon_clk        (mon_clk),
    .mon_start      (mon_start),
    .mon_abort      (mon_abort),
    .mon_win_len    (mon_win_len),
    .mon_num_win    (mon_num_win),
    .mon_spread_max (mon_spread_max),
    .mon_busy       (mon_busy),
    .mon_done       (mon_done),
    .mon_cnt_min    (mon_cnt_min),
    .mon_cnt_max    (mon_cnt_max),
    .mon_spread     (mon_spread),
    .mon_turns      (mon_turns),
    .mon_err        (mon_err),
    .mon_dbg_state  (mon_dbg_state)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int prof [0:15];
  int done_cyc, busy_cnt, busy_at_done, err_c1;
  int s_state, s_busy, s_done, s_min, s_max, s_spread, s_turns, s_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic take_snap();
    s_state  = int'(mon_dbg_state);
    s_busy   = int'(mon_busy);
    s_done   = int'(mon_done);
    s_min    = int'(mon_cnt_min);
    s_max    = int'(mon_cnt_max);
    s_spread = int'(mon_spread);
    s_turns  = int'(mon_turns);
    s_err    = int'(mon_err);
  endtask

  // mode 0: mon_clk = clk_in/4; mode 1: prof[k] one-cycle pulses, 3 cycles apart, inside window k.
  // Cycle c is the period after the c-th posedge following the start sample.
  task automatic run_mon(input int w, input int n, input int lim, input int mode,
                         input int pulse_at, input int abort_at, input int rst_at);
    int limit_c;
    int k, o;
    limit_c      = (n + 1) * w + 8;
    done_cyc     = -1;
    busy_cnt     = 0;
    busy_at_done = -1;
    err_c1       = -1;
    @(negedge clk_in);
    mon_win_len    = 12'(w);
    mon_num_win    = 8'(n);
    mon_spread_max = 12'(lim);
    mon_start      = 1'b1;
    for (int c = 1; c <= limit_c; c++) begin
      @(negedge clk_in);
      if (mon_busy) busy_cnt++;
      if (mon_done && done_cyc < 0) begin
        done_cyc     = c;
        busy_at_done = int'(mon_busy);
      end
      if (c == 1) err_c1 = int'(mon_err);
      if (c == abort_at + 1) take_snap();
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        take_snap();
        break;
      end
      mon_start = (c == pulse_at);
      mon_abort = (c == abort_at);
      if (mode == 0) begin
        mon_clk = ((c >> 1) & 1) != 0;
      end else begin
        k = (c - 1) / w;
        o = (c - 1) % w;
        mon_clk = (k >= 1) && (k <= n) && (o >= 4) && (((o - 4) % 3) == 0) && (((o - 4) / 3) < prof[k]);
      end
    end
    mon_start = 1'b0;
    mon_abort = 1'b0;
    mon_clk   = 1'b0;
  endtask

  task automatic check_results(input string tag, input int mn, input int mx, input int sp,
                               input int tu, input int er);
    check({tag, "_min"},    32'(mon_cnt_min), 32'(mn));
    check({tag, "_max"},    32'(mon_cnt_max), 32'(mx));
    check({tag, "_spread"}, 32'(mon_spread),  32'(sp));
    check({tag, "_turns"},  32'(mon_turns),   32'(tu));
    check({tag, "_err"},    32'(mon_err),     32'(er));
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_state",  32'(mon_dbg_state), 32'd0);
    check("rst_busy",   32'(mon_busy),      32'd0);
    check("rst_done",   32'(mon_done),      32'd0);
    check_results("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // constant clk_in/4: 16 edges in every 64-cycle window
    run_mon(64, 8, 3, 0, -1, -1, -1);
    check("const_done_cyc",  32'(done_cyc),     32'd577);
    check("const_busy_cnt",  32'(busy_cnt),     32'd576);
    check("const_busy_done", 32'(busy_at_done), 32'd0);
    check_results("const", 16, 16, 0, 0, 0);
    check("const_idle", 32'(mon_dbg_state), 32'd0);

    // triangle profile 14,15,16,15,14,15,16,15
    prof[1] = 14; prof[2] = 15; prof[3] = 16; prof[4] = 15;
    prof[5] = 14; prof[6] = 15; prof[7] = 16; prof[8] = 15;
    run_mon(64, 8, 3, 1, -1, -1, -1);
    check("tri_done_cyc", 32'(done_cyc), 32'd577);
    check_results("tri", 14, 16, 2, 3, 0);

    // alternating 12/16 against a limit of 3
    for (int i = 1; i <= 8; i++) prof[i] = (i % 2 == 1) ? 12 : 16;
    run_mon(64, 8, 3, 1, -1, -1, -1);
    check("lim_done_cyc", 32'(done_cyc), 32'd577);
    check_results("lim", 12, 16, 4, 6, 1);
    repeat (20) @(negedge clk_in);
    check("lim_err_sticky", 32'(mon_err), 32'd1);

    // start pulse at cycle 100 is ignored
    run_mon(64, 8, 3, 0, 100, -1, -1);
    check("ign_err_cleared", 32'(err_c1),   32'd0);
    check("ign_done_cyc",    32'(done_cyc), 32'd577);
    check_results("ign", 16, 16, 0, 0, 0);

    // abort at cycle 200 (window 3, after two windows updated min/max)
    run_mon(64, 8, 3, 0, -1, 200, -1);
    check("abt_no_done",  32'(done_cyc), 32'hFFFF_FFFF);
    check("abt_busy_cnt", 32'(busy_cnt), 32'd200);
    check("abt_state",    32'(s_state),  32'd0);
    check("abt_busy",     32'(s_busy),   32'd0);
    check("abt_min",      32'(s_min),    32'd0);
    check("abt_max",      32'(s_max),    32'd0);
    check("abt_err",      32'(s_err),    32'd0);

    // illegal configurations
    run_mon(0, 8, 3, 0, -1, -1, -1);
    check("w0_done_cyc", 32'(done_cyc), 32'd1);
    check("w0_busy_cnt", 32'(busy_cnt), 32'd0);
    check_results("w0", 0, 0, 0, 0, 1);
    run_mon(64, 0, 3, 0, -1, -1, -1);
    check("n0_done_cyc", 32'(done_cyc), 32'd1);
    check("n0_busy_cnt", 32'(busy_cnt), 32'd0);
    check_results("n0", 0, 0, 0, 0, 1);

    // reset during window 3, then a clean rerun
    run_mon(64, 8, 3, 0, -1, -1, 220);
    check("rsm_state", 32'(s_state),  32'd0);
    check("rsm_busy",  32'(s_busy),   32'd0);
    check("rsm_done",  32'(s_done),   32'd0);
    check("rsm_min",   32'(s_min),    32'd0);
    check("rsm_max",   32'(s_max),    32'd0);
    check("rsm_sprd",  32'(s_spread), 32'd0);
    check("rsm_turns", 32'(s_turns),  32'd0);
    check("rsm_err",   32'(s_err),    32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    run_mon(64, 8, 3, 0, -1, -1, -1);
    check("rerun_done_cyc", 32'(done_cyc), 32'd577);
    check_results("rerun", 16, 16, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
